// File: rtl/acc_bank_pkg.sv
// ============================================================================
//  Module : acc_bank_pkg
//  Brief  : Shared widths and saturating/wrapping arithmetic helpers for acc_bank.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package acc_bank_pkg;

   localparam int c_ch_def     = 10;
   localparam int c_in_w_def   = 32;
   localparam int c_acc_w_def  = 32;
   localparam int c_bias_w_def = 8;
   localparam int c_out_w_def  = 32;
   localparam int c_len_w_def  = 8;

   // Helpers work on a fixed wide carrier; callers pass the real target width.
   localparam int c_max_w = 64;

   typedef logic signed [c_max_w-1:0] wide_t;
   typedef logic signed [c_max_w:0]   wide_ext_t;

   typedef struct packed {
      logic  ovf;
      wide_t val;
   } fit_t;

   function automatic fit_t fit_to(input wide_ext_t v, input logic sat, input int w);
      wide_ext_t hi;
      wide_ext_t lo;
      wide_ext_t wrp;
      int        sh;
      fit_t      r;
      hi    = (wide_ext_t'(1) <<< (w - 1)) - wide_ext_t'(1);
      lo    = -hi - wide_ext_t'(1);
      sh    = c_max_w + 1 - w;
      wrp   = (v <<< sh) >>> sh;
      r.ovf = (v > hi) || (v < lo);
      if (r.ovf && sat) begin
         r.val = (v > hi) ? wide_t'(hi) : wide_t'(lo);
      end else begin
         r.val = wide_t'(wrp);
      end
      return r;
   endfunction

   function automatic fit_t sat_add(input wide_t a, input wide_t b, input logic sat, input int w);
      return fit_to(wide_ext_t'(a) + wide_ext_t'(b), sat, w);
   endfunction

   function automatic fit_t sat_narrow(input wide_t a, input logic sat, input int w);
      return fit_to(wide_ext_t'(a), sat, w);
   endfunction

endpackage

`default_nettype wire

// File: rtl/acc_bank_if.sv
// ============================================================================
//  Module : acc_bank_if
//  Brief  : Beat input and result output handshake bundle of acc_bank.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface acc_bank_if
   import acc_bank_pkg::*;
#(
   parameter int CH     = c_ch_def,
   parameter int IN_W   = c_in_w_def,
   parameter int BIAS_W = c_bias_w_def,
   parameter int OUT_W  = c_out_w_def
) ();

   logic                        i_pre_valid;
   logic                        o_pre_ready;
   logic [CH-1:0][IN_W-1:0]     i_res;
   logic [CH-1:0][BIAS_W-1:0]   i_bias;
   logic                        o_post_valid;
   logic                        i_post_ready;
   logic [CH-1:0][OUT_W-1:0]    o_res;
   logic                        o_ovf;

   modport master (
      output i_pre_valid, i_res, i_bias, i_post_ready,
      input  o_pre_ready, o_post_valid, o_res, o_ovf
   );

   modport slave (
      input  i_pre_valid, i_res, i_bias, i_post_ready,
      output o_pre_ready, o_post_valid, o_res, o_ovf
   );

endinterface

`default_nettype wire

// File: rtl/acc_bank_lane.sv
// ============================================================================
//  Module : acc_bank_lane
//  Brief  : One channel: accumulator, bias extend, adder, output narrowing, ovf.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_bank_lane
   import acc_bank_pkg::*;
#(
   parameter int IN_W   = c_in_w_def,
   parameter int ACC_W  = c_acc_w_def,
   parameter int BIAS_W = c_bias_w_def,
   parameter int OUT_W  = c_out_w_def
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_beat,
   input  logic                     i_first,
   input  logic                     i_last,
   input  logic                     i_clr,
   input  logic                     i_sat,
   input  logic signed [IN_W-1:0]   i_res,
   input  logic signed [BIAS_W-1:0] i_bias,
   output logic signed [OUT_W-1:0]  o_res,
   output logic                     o_ovf
);

   function automatic logic [ACC_W:0] add_acc(input wide_t a, input wide_t b, input logic sat);
      fit_t f;
      f = sat_add(a, b, sat, ACC_W);
      return {f.ovf, f.val[ACC_W-1:0]};
   endfunction

   function automatic logic [OUT_W:0] narrow_out(input wide_t a, input logic sat);
      fit_t f;
      f = sat_narrow(a, sat, OUT_W);
      return {f.ovf, f.val[OUT_W-1:0]};
   endfunction

   logic signed [ACC_W-1:0] r_acc;
   logic                    r_ovf_acc;
   logic signed [OUT_W-1:0] r_out;
   logic                    r_ovf_out;

   wide_t                   w_base;
   logic signed [ACC_W-1:0] w_sum_val;
   logic                    w_sum_ovf;
   logic signed [OUT_W-1:0] w_nar_val;
   logic                    w_nar_ovf;
   logic                    w_ovf_frame;

   // The bias replaces the stale accumulator on the first beat of a frame.
   always_comb begin
      w_base                   = i_first ? wide_t'(i_bias) : wide_t'(r_acc);
      {w_sum_ovf, w_sum_val}   = add_acc(w_base, wide_t'(i_res), i_sat);
      {w_nar_ovf, w_nar_val}   = narrow_out(wide_t'(w_sum_val), i_sat);
      w_ovf_frame              = w_sum_ovf | (!i_first & r_ovf_acc);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc     <= '0;
         r_ovf_acc <= 1'b0;
         r_out     <= '0;
         r_ovf_out <= 1'b0;
      end else if (i_clr) begin
         r_acc     <= '0;
         r_ovf_acc <= 1'b0;
      end else if (i_beat) begin
         if (i_last) begin
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_out     <= w_nar_val;
            r_ovf_out <= w_ovf_frame | w_nar_ovf;
         end else begin
            r_acc     <= w_sum_val;
            r_ovf_acc <= w_ovf_frame;
         end
      end
   end

   assign o_res = r_out;
   assign o_ovf = r_ovf_out;

endmodule

`default_nettype wire

// File: rtl/acc_bank.sv
// ============================================================================
//  Module : acc_bank
//  Brief  : Double-buffered multi-channel frame accumulator with per-channel bias.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_bank
   import acc_bank_pkg::*;
#(
   parameter int CH     = c_ch_def,
   parameter int IN_W   = c_in_w_def,
   parameter int ACC_W  = c_acc_w_def,
   parameter int BIAS_W = c_bias_w_def,
   parameter int OUT_W  = c_out_w_def,
   parameter int LEN_W  = c_len_w_def
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [LEN_W-1:0] i_cfg_len,
   input  logic             i_cfg_sat,
   input  logic             i_clr,
   output logic             o_busy,
   acc_bank_if.slave        bus
);

   logic [LEN_W-1:0]          r_cnt;
   logic [LEN_W-1:0]          r_len;
   logic                      r_out_full;

   logic [LEN_W-1:0]          w_len_cfg;
   logic [LEN_W-1:0]          w_len_eff;
   logic                      w_first;
   logic                      w_last;
   logic                      w_pre_fire;
   logic                      w_post_fire;
   logic [CH-1:0]             w_lane_ovf;
   logic [CH-1:0][OUT_W-1:0]  w_lane_res;

   // Frame length is taken live on the first beat, from r_len afterwards.
   assign w_len_cfg = (i_cfg_len == '0) ? LEN_W'(1) : i_cfg_len;
   assign w_first   = (r_cnt == '0);
   assign w_len_eff = w_first ? w_len_cfg : r_len;
   assign w_last    = (r_cnt == w_len_eff - LEN_W'(1));

   assign bus.o_pre_ready = !i_clr && (!w_last || !r_out_full || bus.i_post_ready);
   assign w_pre_fire      = bus.i_pre_valid && bus.o_pre_ready;
   assign w_post_fire     = r_out_full && bus.i_post_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_len      <= '0;
         r_out_full <= 1'b0;
      end else begin
         if (i_clr) begin
            r_cnt <= '0;
         end else if (w_pre_fire) begin
            if (w_first) begin
               r_len <= w_len_cfg;
            end
            r_cnt <= w_last ? '0 : r_cnt + LEN_W'(1);
         end
         // A last beat landing with a drain reloads the buffer and keeps it full.
         if (w_pre_fire && w_last) begin
            r_out_full <= 1'b1;
         end else if (w_post_fire) begin
            r_out_full <= 1'b0;
         end
      end
   end

   generate
      for (genvar g = 0; g < CH; g++) begin : g_lane
         acc_bank_lane #(
            .IN_W   (IN_W),
            .ACC_W  (ACC_W),
            .BIAS_W (BIAS_W),
            .OUT_W  (OUT_W)
         ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_beat  (w_pre_fire),
            .i_first (w_first),
            .i_last  (w_last),
            .i_clr   (i_clr),
            .i_sat   (i_cfg_sat),
            .i_res   (bus.i_res[g]),
            .i_bias  (bus.i_bias[g]),
            .o_res   (w_lane_res[g]),
            .o_ovf   (w_lane_ovf[g])
         );
      end
   endgenerate

   assign bus.o_post_valid = r_out_full;
   assign bus.o_res        = w_lane_res;
   assign bus.o_ovf        = |w_lane_ovf;
   assign o_busy           = (r_cnt != '0) || r_out_full;

endmodule

`default_nettype wire
